// File: rtl/lsu_bus.sv
// Load/store unit bridging core load/store decode to a request/grant memory bus.
// Handles alignment checking, byte-lane steering, load extension and a read timeout.
module lsu_bus #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  load_code,
  input  logic [1:0]  store_code,
  input  logic [31:0] addr,
  input  logic [31:0] data_store,
  output logic [31:0] data_load,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] data_load_q, data_load_d;
  // Access size: 0 byte, 1 half, 2 word.
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        is_load_q, is_load_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        is_ld, is_st, op_valid, aligned;
  logic [1:0]  size_in;
  logic [31:0] lane, ext;
  logic [3:0]  strb;
  logic [31:0] wdata;

  always_comb begin
    is_ld    = (load_code == 3'b000) | (load_code == 3'b001) | (load_code == 3'b010) |
               (load_code == 3'b100) | (load_code == 3'b101);
    is_st    = (store_code != 2'b11);
    op_valid = is_ld | is_st;
    // Load takes priority when both codes are valid.
    size_in  = is_ld ? load_code[1:0] : store_code;
    unique case (size_in)
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'd0:    ext = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'd1:    ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    unique case (size_q)
      2'd0: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{wdat_q[7:0]}};
      end
      2'd1: begin
        strb  = 4'b0011 << {addr_q[1], 1'b0};
        wdata = {2{wdat_q[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = wdat_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    data_load_d = data_load_q;
    size_d      = size_q;
    uns_d       = uns_q;
    is_load_d   = is_load_q;
    misalign_d  = misalign_q;
    bus_err_d   = bus_err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (op_valid) begin
          addr_d     = addr;
          wdat_d     = data_store;
          size_d     = size_in;
          uns_d      = is_ld & load_code[2];
          is_load_d  = is_ld;
          misalign_d = ~aligned;
          bus_err_d  = 1'b0;
          state_d    = aligned ? StReq : StDone;
        end
      end
      StReq: begin
        if (mem_gnt) begin
          cnt_d   = 8'd0;
          state_d = is_load_q ? StWait : StDone;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          data_load_d = ext;
          state_d     = StDone;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      wdat_q      <= 32'd0;
      data_load_q <= 32'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      is_load_q   <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      data_load_q <= data_load_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      is_load_q   <= is_load_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Bus outputs are driven only while a request is outstanding.
  always_comb begin
    mem_req   = (state_q == StReq);
    mem_we    = mem_req & ~is_load_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wstrb = (mem_req & ~is_load_q) ? strb : 4'b0000;
    mem_wdata = mem_req ? wdata : 32'd0;
    lsu_done  = (state_q == StDone);
    misalign  = lsu_done & misalign_q;
    bus_err   = lsu_done & bus_err_q;
    lsu_busy  = ((state_q == StIdle) & op_valid) | (state_q == StReq) | (state_q == StWait);
    data_load = data_load_q;
  end

endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboard bench for lsu_bus: a driver issues directed and random ops with a bus model,
// while independent monitors check bus requests and completions against queued expectations.
module tb_lsu_bus;
  localparam int TO = 64;

  logic        clk, rst;
  logic [2:0]  load_code;
  logic [1:0]  store_code;
  logic [31:0] addr, data_store, data_load;
  logic        lsu_busy, lsu_done, misalign, bus_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  lsu_bus #(.TIMEOUT(8'(TO))) dut (
    .clk(clk), .rst(rst), .load_code(load_code), .store_code(store_code), .addr(addr),
    .data_store(data_store), .data_load(data_load), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
    .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic mis; logic err; logic [31:0] data; int busy; } done_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; int reqc; }
    bus_t;

  done_t       done_q[$];
  bus_t        bus_q[$];
  int          vecs = 0, errs = 0;
  logic [31:0] model_load = 32'd0;
  int          cur_gd = 0, cur_rd = 0;
  logic [31:0] cur_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus slave: grant after cur_gd idle cycles, return read data cur_rd cycles into WAIT
  // (negative cur_rd means never respond).
  initial begin
    bit is_rd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        repeat (cur_gd) begin @(posedge clk); #1; end
        mem_gnt = 1'b1;
        is_rd = !mem_we;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        if (is_rd && cur_rd >= 0) begin
          repeat (cur_rd) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1; mem_rdata = cur_rdata;
          @(posedge clk); #1;
          mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
      end
    end
  end

  // Bus request monitor.
  initial begin
    int req_cnt = 0;
    bus_t b;
    forever begin
      @(negedge clk);
      if (rst) req_cnt = 0;
      else if (mem_req) begin
        req_cnt++;
        if (bus_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_req: got mem_req=1 addr 0x%08h, expected no request", mem_addr);
        end else begin
          b = bus_q[0];
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_we", 32'(mem_we), 32'(b.we));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(b.strb));
          if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
          if (mem_gnt) begin
            chk("req_cycles", req_cnt, b.reqc);
            void'(bus_q.pop_front());
            req_cnt = 0;
          end
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    int busy_cnt = 0;
    done_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else begin
        if (lsu_busy) busy_cnt++;
        if (lsu_done) begin
          if (done_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_done: got lsu_done=1, expected 0");
          end else begin
            e = done_q.pop_front();
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("bus_err", 32'(bus_err), 32'(e.err));
            chk("data_load", data_load, e.data);
            chk("busy_cycles", busy_cnt, e.busy);
          end
          busy_cnt = 0;
        end else if (misalign || bus_err) begin
          errs++;
          $display("FAIL stray_flag: got misalign=%0b bus_err=%0b, expected 0 outside done",
                   misalign, bus_err);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] lc, input logic [1:0] sc, input logic [31:0] a,
                       input logic [31:0] d, input int gd, input int rd, input logic [31:0] rdat);
    bit isld, isst, sgn;
    int sz, off, n;
    done_t e;
    bus_t b;
    logic [31:0] v, mask;
    isld = lc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    isst = (sc != 2'd3);
    load_code = lc; store_code = sc; addr = a; data_store = d;
    if (!isld && !isst) begin
      @(negedge clk);
      chk("noop_busy", 32'(lsu_busy), 32'd0);
      @(posedge clk); #1;
      return;
    end
    sz  = isld ? (1 << lc[1:0]) : (1 << sc);
    sgn = isld && !lc[2];
    off = int'(a[1:0]);
    cur_gd = gd; cur_rd = rd; cur_rdata = rdat;
    e.mis = (int'(a[1:0]) % sz) != 0;
    e.err = 1'b0;
    if (!e.mis) begin
      b.addr = a & 32'hFFFF_FFFC;
      b.we   = !isld;
      b.reqc = gd + 1;
      b.strb = isld ? 4'b0000 : 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
      bus_q.push_back(b);
      if (isld) begin
        if (rd < 0) e.err = 1'b1;
        else begin
          mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
          v = (rdat >> (8 * off)) & mask;
          if (sgn && sz < 4 && v[8*sz-1]) v = v | ~mask;
          model_load = v;
        end
      end
      e.busy = 2 + gd + (isld ? ((rd < 0) ? TO : rd + 1) : 0);
    end else e.busy = 1;
    e.data = model_load;
    done_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_done && n < TO + 40);
    if (!lsu_done) begin
      errs++;
      $display("FAIL done_timeout: got no lsu_done in %0d cycles, expected a completion", n);
    end
    @(posedge clk); #1;
    load_code = 3'd7; store_code = 2'd3;
  endtask

  initial begin
    int gd, rd, r;
    rst = 1'b1; load_code = 3'd7; store_code = 2'd3; addr = 32'd0; data_store = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_outs", {mem_we, mem_wstrb, lsu_done, misalign, bus_err, lsu_busy}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_data_load", data_load, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", {mem_req, mem_we, mem_wstrb, lsu_done, misalign, bus_err}, 32'd0);
    @(posedge clk); #1;

    issue(3'd0, 2'd3, 32'h0000_0103, 32'd0, 0, 1, 32'h80FF_0000);
    issue(3'd7, 2'd1, 32'h0000_0202, 32'h1234_ABCD, 0, -1, 32'd0);
    issue(3'd2, 2'd3, 32'h0000_0101, 32'd0, 0, 0, 32'd0);
    issue(3'd5, 2'd3, 32'h0000_0000, 32'd0, 5, 0, 32'h0000_8001);
    issue(3'd2, 2'd3, 32'h0000_0010, 32'd0, 0, -1, 32'd0);
    issue(3'd2, 2'd3, 32'h0000_0014, 32'd0, 0, TO - 1, 32'hCAFE_F00D);
    issue(3'd3, 2'd3, 32'h0000_0020, 32'd0, 0, 0, 32'd0);
    issue(3'd6, 2'd3, 32'h0000_0020, 32'd0, 0, 0, 32'd0);
    issue(3'd1, 2'd0, 32'h0000_0003, 32'h55AA_55AA, 0, 0, 32'd0);
    issue(3'd4, 2'd2, 32'h0000_0032, 32'hFFFF_FFFF, 1, 2, 32'h00F1_0000);

    for (int k = 0; k < 300; k++) begin
      gd = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 2));
      r  = int'($urandom_range(0, 19));
      rd = (r == 0) ? -1 : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom, gd, rd,
            $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset while waiting for read data; the late rvalid must be ignored.
    cur_gd = 0; cur_rd = 5; cur_rdata = 32'hDEAD_BEEF;
    bus_q.push_back('{addr: 32'h0000_0040, we: 1'b0, strb: 4'b0000, wdata: 32'd0, reqc: 1});
    load_code = 3'd2; store_code = 2'd3; addr = 32'h0000_0040;
    @(posedge clk); #1;
    load_code = 3'd7;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_load = 32'd0;
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort_data_load", data_load, model_load);
    chk("abort_idle", {lsu_busy, mem_req, lsu_done}, 32'd0);

    repeat (4) @(posedge clk);
    chk("done_q_empty", done_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter TIMEOUT, default 8'd64: cycles in WAIT before a bus error SHALL be declared.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_code  input  3  decoder load code; funct3 encoding (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU); 111 = no load.
REQ-005 store_code  input  2  decoder store code (00 SB, 01 SH, 10 SW); 11 = no store.
REQ-006 addr  input  32  effective byte address from ALU.
REQ-007 data_store  input  32  rs2 value to store.
REQ-008 data_load  output  32  extended load result, registered.
REQ-009 lsu_busy  output  1  stall to core; PC SHALL hold while high.
REQ-010 lsu_done  output  1  one-cycle completion pulse.
REQ-011 misalign  output  1  completion flag: access misaligned, no bus traffic issued.
REQ-012 bus_err  output  1  completion flag: WAIT timeout.
REQ-013 mem_req / mem_we  output  1 each  bus request, write enable.
REQ-014 mem_addr  output  32  word address ({addr[31:2],2'b00}).
REQ-015 mem_wstrb  output  4  byte-lane write strobes.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_gnt  input  1  bus accepts request this cycle.
REQ-018 mem_rvalid / mem_rdata  input  1 / 32  read data return.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; encoding free.
REQ-020 op_valid = (load_code in {000,001,010,100,101}) | (store_code != 11); load_code 011/110 SHALL be no-op.
REQ-021 Load and store both valid simultaneously: load SHALL win, store ignored.
REQ-022 IDLE & op_valid & aligned: capture addr, data_store, op, is_load into registers; next REQ.
REQ-023 Alignment: H ops need addr[0]=0; W ops need addr[1:0]=00; byte ops always aligned.
REQ-024 IDLE & op_valid & misaligned: next DONE with misalign=1; mem_req SHALL never assert.
REQ-025 REQ: mem_req=1, mem_we=~is_load, mem_addr/wstrb/wdata from captured values, held stable until mem_gnt.
REQ-026 REQ & mem_gnt & store: next DONE. REQ & mem_gnt & load: next WAIT. mem_req SHALL deassert the cycle after gnt.
REQ-027 WAIT: count cycles from 0; mem_rvalid → latch extended data into data_load, next DONE; count reaches TIMEOUT-1 without rvalid → next DONE with bus_err=1, data_load unchanged.
REQ-028 rvalid in the same cycle the count hits TIMEOUT-1: data SHALL be accepted, no bus_err.
REQ-029 REQ has no timeout; it waits indefinitely for gnt.
REQ-030 DONE: lsu_done=1 for exactly one cycle, misalign/bus_err valid only this cycle, next IDLE unconditionally (op inputs ignored).
REQ-031 lsu_busy = (IDLE & op_valid) | REQ | WAIT; 0 in DONE, so core advances on the DONE edge; inputs SHALL be held by core while busy.
REQ-032 Stores: SB wstrb=0001<<addr[1:0], wdata={4{d[7:0]}}; SH wstrb=0011<<{addr[1],0}, wdata={2{d[15:0]}}; SW wstrb=1111, wdata=d. Loads: wstrb=0000.
REQ-033 Load extract: lane = rdata>>(8*addr[1:0]); LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW unchanged.
REQ-034 data_load SHALL hold value until next successful load; stores/errors leave it unchanged.

Reset
REQ-035 rst=1 at clock edge: state IDLE, WAIT counter 0, data_load=0, all captured registers 0.
REQ-036 During and after reset before any op: mem_req, mem_we, mem_wstrb, lsu_done, misalign, bus_err=0; mem_addr, mem_wdata=0.
REQ-037 Reset mid-transaction (REQ or WAIT) SHALL abort with no lsu_done; later rvalid in IDLE SHALL be ignored.

Verification
REQ-038 LB addr=0x103, rdata=0x80FF_0000, rvalid 2 cycles after gnt → data_load=0xFFFF_FF80, lsu_done one pulse, busy 4 cycles.
REQ-039 SH addr=0x202, data_store=0x1234_ABCD, gnt immediate → mem_addr=0x200, wstrb=1100, wdata=0xABCD_ABCD, mem_we=1.
REQ-040 LW addr=0x101 → misalign=1 with lsu_done in 2nd cycle, mem_req never high, data_load unchanged.
REQ-041 LHU addr=0x0, gnt held 0 for 5 cycles then 1, rdata=0x0000_8001 → mem_req high 6 cycles, data_load=0x0000_8001.
REQ-042 LW, gnt, no rvalid for TIMEOUT cycles → bus_err=1 with lsu_done; rvalid exactly at cycle TIMEOUT-1 → no bus_err.
REQ-043 rst asserted in WAIT, then rvalid=1 → state IDLE, no lsu_done, data_load=0.
